// File: rtl/jtag_host_ctrl.sv
`timescale 1ns/1ps
// jtag_host_ctrl: on-chip JTAG initiator. Turns one-word scan commands
// (TAP reset, IR scan, DR scan, idle-run) into TCK/TMS/TDI waveforms and
// returns the TDO bits captured during the shift phase.
// Ports: clk/rst_n (async, active low); cmd_valid/cmd_ready handshake with
// cmd_op/cmd_len/cmd_data; rsp_valid pulse with rsp_data; busy;
// TCK/TMS/TDI driven to the TAP, TDO sampled from it.
module jtag_host_ctrl #(
    parameter int DIV       = 2,
    parameter int MAX_LEN   = 16,
    parameter int IDLE_TCKS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [4:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_HDR, S_SHIFT, S_TAIL, S_RTI, S_DONE
    } state_t;

    state_t             state_q, state_d, nxt;
    logic [4:0]         cnt_q, cnt_d;
    logic [DW-1:0]      div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [1:0]         op_q, op_d;
    logic [4:0]         len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               auto_q, auto_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               last;
    logic [4:0]         clen;
    logic [1:0]         pins;
    logic               is_ir;
    logic [4:0]         rti_len;

    assign is_ir   = (op_q == 2'b01);
    assign rti_len = (op_q == 2'b11) ? len_q : 5'(IDLE_TCKS);

    // {TMS, TDI} to present for bit c of state st
    function automatic logic [1:0] pin_val(
        input state_t             st,
        input logic [4:0]         c,
        input logic               ir,
        input logic [4:0]         n,
        input logic [MAX_LEN-1:0] d
    );
        logic [1:0] r;
        r = 2'b00;
        case (st)
            S_RESET: r = {c < 5'd5, 1'b0};
            S_HDR: begin
                // last header edge is Capture: TMS=1 skips Shift when len=0
                if (c == (ir ? 5'd3 : 5'd2)) r = {n == 5'd0, 1'b0};
                else r = {ir ? (c < 5'd2) : (c == 5'd0), 1'b0};
            end
            S_SHIFT: r = {c == n - 5'd1, d[c[IW-1:0]]};
            S_TAIL:  r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        auto_d      = auto_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        pins        = 2'b00;
        last        = 1'b0;
        nxt         = state_q;
        clen        = (cmd_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : cmd_len;

        unique case (state_q)
            S_RESET: begin
                last = (cnt_q == 5'd5);
                nxt  = auto_q ? S_IDLE : S_DONE;
            end
            S_HDR: begin
                last = (cnt_q == (is_ir ? 5'd3 : 5'd2));
                nxt  = (len_q == 5'd0) ? S_TAIL : S_SHIFT;
            end
            S_SHIFT: begin
                last = (cnt_q == len_q - 5'd1);
                nxt  = S_TAIL;
            end
            S_TAIL: begin
                last = 1'b1;
                nxt  = S_RTI;
            end
            S_RTI: begin
                last = (cnt_q == rti_len - 5'd1);
                nxt  = S_DONE;
            end
            default: begin
                last = 1'b0;
                nxt  = state_q;
            end
        endcase

        if (state_q == S_IDLE) begin
            if (cmd_valid) begin
                op_d   = cmd_op;
                len_d  = clen;
                data_d = cmd_data;
                cap_d  = '0;
                cnt_d  = 5'd0;
                div_d  = '0;
                tck_d  = 1'b0;
                unique case (cmd_op)
                    2'b00:   state_d = S_RESET;
                    2'b01,
                    2'b10:   state_d = S_HDR;
                    default: state_d = (clen == 5'd0) ? S_DONE : S_RTI;
                endcase
                pins  = pin_val(state_d, 5'd0, cmd_op == 2'b01,
                                clen, cmd_data);
                tms_d = (state_d == S_DONE) ? tms_q : pins[1];
                tdi_d = pins[0];
            end
        end else if (state_q == S_DONE) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
            state_d     = S_IDLE;
        end else begin
            if (div_q == DW'(DIV - 1)) begin
                div_d = '0;
                tck_d = ~tck_q;
                if (!tck_q) begin
                    // rising TCK: sample TDO
                    if (state_q == S_SHIFT) cap_d[cnt_q[IW-1:0]] = TDO;
                end else begin
                    // falling TCK: advance to the next bit
                    if (last) begin
                        state_d = nxt;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                    if (state_d == S_DONE || state_d == S_IDLE) begin
                        tdi_d = 1'b0;
                    end else begin
                        pins  = pin_val(state_d, cnt_d, is_ir, len_q, data_q);
                        tms_d = pins[1];
                        tdi_d = pins[0];
                    end
                    if (state_d == S_IDLE) auto_d = 1'b0;
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            cnt_q       <= 5'd0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            op_q        <= 2'b00;
            len_q       <= 5'd0;
            data_q      <= '0;
            cap_q       <= '0;
            auto_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            auto_q      <= auto_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_host_ctrl.sv
`timescale 1ns/1ps
// Bench for jtag_host_ctrl: a behavioural TAP (4-bit IR, 16-bit loop DR)
// answers TDO; expected TMS/TDI streams and responses come from scan rules.
module tb_jtag_host_ctrl;

    localparam int DIV       = 2;
    localparam int MAX_LEN   = 16;
    localparam int IDLE_TCKS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        cmd_ready, rsp_valid, busy, TCK, TMS, TDI, TDO;
    logic [15:0] rsp_data;

    int total = 0;
    int bad = 0;

    jtag_host_ctrl #(.DIV(DIV), .MAX_LEN(MAX_LEN), .IDLE_TCKS(IDLE_TCKS)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural TAP ----------------
    int          tap_st = 0;
    logic [3:0]  ir_sh = 4'h0;
    logic [15:0] dr_sh = 16'h0;
    logic [15:0] loop_reg = 16'h0;
    logic [15:0] loop_init = 16'h0;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            0: return m ? 0 : 1;    1: return m ? 2 : 1;
            2: return m ? 9 : 3;    3: return m ? 5 : 4;
            4: return m ? 5 : 4;    5: return m ? 8 : 6;
            6: return m ? 7 : 6;    7: return m ? 8 : 4;
            8: return m ? 2 : 1;    9: return m ? 0 : 10;
            10: return m ? 12 : 11; 11: return m ? 12 : 11;
            12: return m ? 15 : 13; 13: return m ? 14 : 13;
            14: return m ? 15 : 11; default: return m ? 2 : 1;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tap_st)
            0:  loop_reg = loop_init;
            3:  dr_sh = loop_reg;
            4:  dr_sh = {TDI, dr_sh[15:1]};
            8:  loop_reg = dr_sh;
            10: ir_sh = 4'b0001;
            11: ir_sh = {TDI, ir_sh[3:1]};
            default: ;
        endcase
        tap_st = tap_next(tap_st, TMS);
    end

    assign TDO = (tap_st == 4) ? dr_sh[0] : (tap_st == 11) ? ir_sh[0] : 1'b0;

    // ---------------- pin monitors ----------------
    int          n_tck = 0, clk_cnt = 0, last_rise = 0;
    int          per_bad = 0, glitch = 0, rsp_cnt = 0, acc_cnt = 0;
    logic [63:0] tms_vec = 64'h0, tdi_vec = 64'h0;
    logic        tms_r = 1'b0, tdi_r = 1'b0;
    time         last_fall = 0, rsp_rise = 0;

    always @(posedge clk) begin
        clk_cnt++;
        if (cmd_valid && cmd_ready) acc_cnt++;
    end

    always @(posedge TCK) begin
        if (n_tck > 0 && clk_cnt - last_rise != 2 * DIV) per_bad++;
        last_rise = clk_cnt;
        if (n_tck < 64) begin
            tms_vec[n_tck] = TMS;
            tdi_vec[n_tck] = TDI;
        end
        n_tck++;
        tms_r = TMS;
        tdi_r = TDI;
    end

    always @(negedge TCK) last_fall = $time;
    always @(posedge rsp_valid) rsp_rise = $time;

    always @(negedge clk) begin
        if (TCK && (TMS !== tms_r || TDI !== tdi_r)) glitch++;
        if (rsp_valid) rsp_cnt++;
    end

    // ---------------- reference model ----------------
    logic [63:0] exp_tms, exp_tdi;
    int          exp_n;
    logic [15:0] exp_loop = 16'h0;

    task automatic push(input logic m, input logic d);
        exp_tms[exp_n] = m;
        exp_tdi[exp_n] = d;
        exp_n++;
    endtask

    task automatic build_exp(input logic [1:0] op, input int len,
                             input logic [15:0] d);
        int l;
        l = (len > MAX_LEN) ? MAX_LEN : len;
        exp_tms = 64'h0;
        exp_tdi = 64'h0;
        exp_n   = 0;
        if (op == 2'd0) begin
            for (int i = 0; i < 5; i++) push(1'b1, 1'b0);
            push(1'b0, 1'b0);
        end else if (op == 2'd3) begin
            for (int i = 0; i < l; i++) push(1'b0, 1'b0);
        end else begin
            push(1'b1, 1'b0);
            if (op == 2'd1) push(1'b1, 1'b0);
            push(1'b0, 1'b0);
            push(l == 0, 1'b0);
            for (int i = 0; i < l; i++) push(i == l - 1, d[i]);
            push(1'b1, 1'b0);
            push(1'b0, 1'b0);
            for (int i = 0; i < IDLE_TCKS - 1; i++) push(1'b0, 1'b0);
        end
    endtask

    task automatic predict(input logic [1:0] op, input int len,
                           input logic [15:0] d, output logic [15:0] r);
        int          l;
        logic [31:0] m;
        l = (len > MAX_LEN) ? MAX_LEN : len;
        m = (32'd1 << l) - 32'd1;
        r = 16'h0;
        case (op)
            2'd0: exp_loop = loop_init;
            2'd1: r = 16'({12'h0, d, 4'b0001} & m);
            2'd2: begin
                r = 16'({16'h0, exp_loop} & m);
                exp_loop = 16'(({16'h0, exp_loop} >> l) |
                               (({16'h0, d} & m) << (16 - l)));
            end
            default: r = 16'h0;
        endcase
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = cmd_ready;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] len,
                           input logic [15:0] d, output bit ok,
                           output logic [15:0] r);
        int t;
        bit rdy;
        @(negedge clk);
        wait_ready(rdy);
        n_tck = 0; per_bad = 0; glitch = 0;
        tms_vec = 64'h0; tdi_vec = 64'h0;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_len = 5'($urandom); cmd_data = 16'($urandom);
        t = 0;
        while (!rsp_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = rsp_valid && rdy;
        r  = rsp_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({TCK, TMS, TDI, cmd_ready, busy, rsp_valid} !== 6'b010010 ||
            rsp_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_vals got=%b/%h want=010010/0000",
                     {TCK, TMS, TDI, cmd_ready, busy, rsp_valid}, rsp_data);
        end
        n_tck = 0; per_bad = 0; rsp_cnt = 0;
        tms_vec = 64'h0; tdi_vec = 64'h0;
        rst_n = 1'b1;
        wait_ready(ok);
        total++;
        if (!ok || n_tck !== 6 || tms_vec !== 64'h1F) begin
            bad++;
            $display("FAIL auto_reset_tms got=%h/%0d want=1f/6", tms_vec, n_tck);
        end
        total++;
        if (per_bad !== 0 || rsp_cnt !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL auto_reset_misc per_bad=%0d rsp=%0d busy=%b want 0/0/0",
                     per_bad, rsp_cnt, busy);
        end
        exp_loop = loop_init;
    endtask

    task automatic test_ir;
        bit ok;
        logic [15:0] r, er, d;
        logic [4:0] l;
        run_cmd(2'd1, 5'd4, 16'h0005, ok, r);
        total++;
        if (!ok || r !== 16'h0001) begin
            bad++;
            $display("FAIL ir4_rsp got=%h want=0001", r);
        end
        total++;
        if (n_tck !== 12 || tms_vec !== 64'h183 || tdi_vec !== 64'h50 ||
            glitch !== 0 || per_bad !== 0) begin
            bad++;
            $display("FAIL ir4_pins tms=%h tdi=%h n=%0d g=%0d want 183/50/12/0",
                     tms_vec, tdi_vec, n_tck, glitch);
        end
        for (int k = 0; k < 4; k++) begin
            l = 5'($urandom_range(0, 8));
            d = 16'($urandom);
            build_exp(2'd1, int'(l), d);
            predict(2'd1, int'(l), d, er);
            run_cmd(2'd1, l, d, ok, r);
            total++;
            if (!ok || r !== er || tms_vec !== exp_tms || tdi_vec !== exp_tdi ||
                n_tck !== exp_n) begin
                bad++;
                $display("FAIL ir_rand len=%0d rsp=%h/%h tms=%h/%h n=%0d/%0d",
                         l, r, er, tms_vec, exp_tms, n_tck, exp_n);
            end
        end
    endtask

    task automatic test_dr;
        bit ok;
        logic [15:0] r, er;
        loop_init = 16'h1234;
        predict(2'd0, 0, 16'h0, er);
        run_cmd(2'd0, 5'd0, 16'h0, ok, r);
        total++;
        if (!ok || r !== 16'h0 || tms_vec !== 64'h1F || n_tck !== 6) begin
            bad++;
            $display("FAIL tap_reset_cmd rsp=%h tms=%h n=%0d want 0/1f/6",
                     r, tms_vec, n_tck);
        end
        predict(2'd2, 16, 16'hAAAA, er);
        run_cmd(2'd2, 5'd16, 16'hAAAA, ok, r);
        total++;
        if (!ok || r !== 16'h1234) begin
            bad++;
            $display("FAIL dr16_first got=%h want=1234", r);
        end
        predict(2'd2, 16, 16'h0000, er);
        run_cmd(2'd2, 5'd16, 16'h0000, ok, r);
        total++;
        if (!ok || r !== 16'hAAAA) begin
            bad++;
            $display("FAIL dr16_second got=%h want=aaaa", r);
        end
    endtask

    task automatic test_dr_len;
        bit ok;
        logic [15:0] r, er, d;
        predict(2'd2, 0, 16'hFFFF, er);
        run_cmd(2'd2, 5'd0, 16'hFFFF, ok, r);
        total++;
        if (!ok || r !== 16'h0 || tms_vec !== 64'h0D || tdi_vec !== 64'h0 ||
            n_tck !== 7) begin
            bad++;
            $display("FAIL dr_len0 rsp=%h tms=%h tdi=%h n=%0d want 0/0d/0/7",
                     r, tms_vec, tdi_vec, n_tck);
        end
        d = 16'($urandom);
        build_exp(2'd2, 20, d);
        predict(2'd2, 20, d, er);
        run_cmd(2'd2, 5'd20, d, ok, r);
        total++;
        if (!ok || n_tck !== 3 + 16 + 1 + IDLE_TCKS || r !== er ||
            tms_vec !== exp_tms || tdi_vec !== exp_tdi) begin
            bad++;
            $display("FAIL dr_len20 n=%0d want=%0d rsp=%h want=%h",
                     n_tck, 3 + 16 + 1 + IDLE_TCKS, r, er);
        end
    endtask

    task automatic test_idle;
        bit ok;
        logic [15:0] r;
        run_cmd(2'd3, 5'd10, 16'hFFFF, ok, r);
        total++;
        if (!ok || n_tck !== 10 || tms_vec !== 64'h0 || r !== 16'h0) begin
            bad++;
            $display("FAIL idle10 n=%0d tms=%h rsp=%h want 10/0/0", n_tck, tms_vec, r);
        end
        total++;
        if (rsp_rise - last_fall !== 10) begin
            bad++;
            $display("FAIL idle_rsp_delay got=%0t want=10", rsp_rise - last_fall);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int a0, t;
        logic [15:0] er;
        @(negedge clk);
        wait_ready(ok);
        build_exp(2'd2, 8, 16'h00C3);
        predict(2'd2, 8, 16'h00C3, er);
        a0 = acc_cnt;
        n_tck = 0; tms_vec = 64'h0; tdi_vec = 64'h0;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'd8; cmd_data = 16'h00C3;
        @(negedge clk);
        t = 0;
        while (!rsp_valid && t < 2000) begin
            cmd_op = 2'($urandom); cmd_len = 5'($urandom); cmd_data = 16'($urandom);
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        total++;
        if (acc_cnt - a0 !== 1 || !rsp_valid) begin
            bad++;
            $display("FAIL b2b_accepts got=%0d want=1", acc_cnt - a0);
        end
        total++;
        if (rsp_data !== er || tms_vec !== exp_tms || tdi_vec !== exp_tdi) begin
            bad++;
            $display("FAIL b2b_data rsp=%h want=%h tdi=%h want=%h",
                     rsp_data, er, tdi_vec, exp_tdi);
        end
    endtask

    task automatic test_random;
        bit ok;
        logic [1:0] op;
        logic [4:0] l;
        logic [15:0] d, r, er;
        for (int k = 0; k < 10; k++) begin
            op = 2'($urandom_range(0, 3));
            l  = 5'($urandom_range(0, 20));
            d  = 16'($urandom);
            build_exp(op, int'(l), d);
            predict(op, int'(l), d, er);
            run_cmd(op, l, d, ok, r);
            total++;
            if (!ok || r !== er) begin
                bad++;
                $display("FAIL rand_rsp op=%0d len=%0d got=%h want=%h", op, l, r, er);
            end
            total++;
            if (tms_vec !== exp_tms || tdi_vec !== exp_tdi || n_tck !== exp_n ||
                glitch !== 0 || per_bad !== 0) begin
                bad++;
                $display("FAIL rand_pins op=%0d len=%0d tms=%h/%h tdi=%h/%h n=%0d/%0d",
                         op, l, tms_vec, exp_tms, tdi_vec, exp_tdi, n_tck, exp_n);
            end
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        int t, rc;
        logic [15:0] r, er;
        @(negedge clk);
        wait_ready(ok);
        n_tck = 0;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'd16; cmd_data = 16'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (n_tck < 10 && t < 2000) begin
            #1;
            t++;
        end
        rst_n = 1'b0;
        rc = rsp_cnt;
        #1;
        total++;
        if (n_tck !== 10 || TCK !== 1'b0 || TMS !== 1'b1) begin
            bad++;
            $display("FAIL abort_pins n=%0d TCK=%b TMS=%b want 10/0/1", n_tck, TCK, TMS);
        end
        repeat (3) @(negedge clk);
        n_tck = 0; tms_vec = 64'h0;
        rst_n = 1'b1;
        wait_ready(ok);
        total++;
        if (!ok || rsp_cnt !== rc || n_tck !== 6 || tms_vec !== 64'h1F) begin
            bad++;
            $display("FAIL abort_recover rsp=%0d/%0d tms=%h n=%0d want 1f/6",
                     rsp_cnt, rc, tms_vec, n_tck);
        end
        exp_loop = loop_init;
        build_exp(2'd1, 4, 16'h000A);
        predict(2'd1, 4, 16'h000A, er);
        run_cmd(2'd1, 5'd4, 16'h000A, ok, r);
        total++;
        if (!ok || r !== er || tms_vec !== exp_tms || tdi_vec !== exp_tdi) begin
            bad++;
            $display("FAIL abort_ir rsp=%h want=%h tms=%h want=%h",
                     r, er, tms_vec, exp_tms);
        end
    endtask

    initial begin
        test_reset;
        test_ir;
        test_dr;
        test_dr_len;
        test_idle;
        test_back_to_back;
        test_random;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
